// File: rtl/tlight_pkg.sv
// Shared definitions for the traffic-light controller, its monitor and their benches:
// phase encoding, one-hot light values and monitor error codes.
package tlight_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_G = 3'b010;
  localparam logic [2:0] LIGHT_Y = 3'b001;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_ILLEGAL_ENC = 3'd1,
    ERR_BAD_SEQ     = 3'd2,
    ERR_TOO_SHORT   = 3'd3,
    ERR_TOO_LONG    = 3'd4
  } err_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tlight_monitor_dwell_chk.sv
// Saturating dwell counter plus MIN/MAX comparison for the current phase.
// Only built when TLIGHT_MON_DWELL_EN is defined.
`ifdef TLIGHT_MON_DWELL_EN
module tlight_dwell_chk
  import tlight_pkg::*;
#(
  parameter int unsigned RED_MIN = 3,
  parameter int unsigned RED_MAX = 20,
  parameter int unsigned GRN_MIN = 3,
  parameter int unsigned GRN_MAX = 20,
  parameter int unsigned YEL_MIN = 1,
  parameter int unsigned YEL_MAX = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  phase_e           i_phase,
  input  logic             i_restart,
  input  logic             i_incr,
  output logic [CNT_W-1:0] o_dwell,
  output logic             o_short,
  output logic             o_long
);

  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] w_min;
  logic [CNT_W-1:0] w_max;

  // Neither strobe means the monitor dropped to SYNC, so the count clears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell <= '0;
    end else if (i_restart) begin
      r_dwell <= CNT_W'(1);
    end else if (i_incr) begin
      if (r_dwell != '1) r_dwell <= r_dwell + 1'b1;
    end else begin
      r_dwell <= '0;
    end
  end

  always_comb begin
    w_min = '0;
    w_max = '1;
    case (i_phase)
      PH_RED:    begin w_min = CNT_W'(RED_MIN); w_max = CNT_W'(RED_MAX); end
      PH_GREEN:  begin w_min = CNT_W'(GRN_MIN); w_max = CNT_W'(GRN_MAX); end
      PH_YELLOW: begin w_min = CNT_W'(YEL_MIN); w_max = CNT_W'(YEL_MAX); end
      default:   ;
    endcase
  end

  assign o_dwell = r_dwell;
  assign o_short = (r_dwell < w_min);
  assign o_long  = (r_dwell == w_max);

endmodule
`endif

// File: rtl/tlight_monitor.sv
// Passive checker of the rgy light bus: phase tracking, dwell measurement, cycle count
// and violation reporting. Dwell MIN/MAX checks are built only with TLIGHT_MON_DWELL_EN.
module tlight_monitor
  import tlight_pkg::*;
#(
  parameter int unsigned RED_MIN = 3,
  parameter int unsigned RED_MAX = 20,
  parameter int unsigned GRN_MIN = 3,
  parameter int unsigned GRN_MAX = 20,
  parameter int unsigned YEL_MIN = 1,
  parameter int unsigned YEL_MAX = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       light,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [15:0]      cycles,
  output logic             err_pulse,
  output logic             err,
  output logic [2:0]       err_code
);

  localparam int unsigned SAT = (1 << CNT_W) - 1;

  if (RED_MIN >= SAT || RED_MAX >= SAT || GRN_MIN >= SAT ||
      GRN_MAX >= SAT || YEL_MIN >= SAT || YEL_MAX >= SAT) begin : g_bad_param
    $error("tlight_monitor: dwell limits must be below 2**CNT_W-1");
  end

  logic [2:0]       r_light_q;
  phase_e           r_phase;
  phase_e           w_phase_nxt;
  phase_e           w_obs;
  logic             w_obs_legal;
  logic             w_restart;
  logic             w_incr;
  logic             w_short;
  logic             w_long;
  logic             w_cyc_inc;
  err_e             w_viol;
  logic [CNT_W-1:0] w_dwell;
  logic [15:0]      r_cycles;
  logic             r_err_pulse;
  logic             r_err;
  err_e             r_err_code;

  always_comb begin
    case (r_light_q)
      LIGHT_R: w_obs = PH_RED;
      LIGHT_G: w_obs = PH_GREEN;
      LIGHT_Y: w_obs = PH_YELLOW;
      default: w_obs = PH_SYNC;
    endcase
  end

  assign w_obs_legal = (w_obs != PH_SYNC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_light_q <= '0;
      r_phase   <= PH_SYNC;
    end else begin
      r_light_q <= light;
      r_phase   <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_restart   = 1'b0;
    w_incr      = 1'b0;
    w_cyc_inc   = 1'b0;
    w_viol      = ERR_NONE;
    if (r_phase == PH_SYNC) begin
      if (w_obs_legal) begin
        w_phase_nxt = w_obs;
        w_restart   = 1'b1;
      end
    end else if (!w_obs_legal) begin
      w_phase_nxt = PH_SYNC;
      w_viol      = ERR_ILLEGAL_ENC;
    end else if (w_obs == r_phase) begin
      w_incr = 1'b1;
      if (w_long) w_viol = ERR_TOO_LONG;
    end else begin
      w_phase_nxt = w_obs;
      w_restart   = 1'b1;
      if (w_obs == next_phase(r_phase)) begin
        if (w_short) w_viol = ERR_TOO_SHORT;
        w_cyc_inc = (r_phase == PH_YELLOW);
      end else begin
        w_viol = ERR_BAD_SEQ;
      end
    end
  end

`ifdef TLIGHT_MON_DWELL_EN
  tlight_dwell_chk #(
    .RED_MIN (RED_MIN),
    .RED_MAX (RED_MAX),
    .GRN_MIN (GRN_MIN),
    .GRN_MAX (GRN_MAX),
    .YEL_MIN (YEL_MIN),
    .YEL_MAX (YEL_MAX),
    .CNT_W   (CNT_W)
  ) u_dwell_chk (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_phase   (r_phase),
    .i_restart (w_restart),
    .i_incr    (w_incr),
    .o_dwell   (w_dwell),
    .o_short   (w_short),
    .o_long    (w_long)
  );
`else
  logic [CNT_W-1:0] r_dwell;

  // Same counter as the checker sub-module, minus the comparators.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
    end else if (w_restart) begin
      r_dwell <= CNT_W'(1);
    end else if (w_incr) begin
      if (r_dwell != '1) r_dwell <= r_dwell + 1'b1;
    end else begin
      r_dwell <= '0;
    end
  end

  assign w_dwell = r_dwell;
  assign w_short = 1'b0;
  assign w_long  = 1'b0;
`endif

  // A violation in the same cycle as clear wins and reloads the code.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycles    <= '0;
      r_err_pulse <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      if (w_cyc_inc) r_cycles <= r_cycles + 1'b1;
      r_err_pulse <= (w_viol != ERR_NONE);
      if (w_viol != ERR_NONE) begin
        r_err <= 1'b1;
        if (!r_err || clear) r_err_code <= w_viol;
      end else if (clear) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign phase     = r_phase;
  assign dwell     = w_dwell;
  assign cycles    = r_cycles;
  assign err_pulse = r_err_pulse;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_tlight_monitor.sv
// Self-checking bench for tlight_monitor: directed scenarios plus random light traffic,
// compared against a behavioural model of the phase rules. Honours TLIGHT_MON_DWELL_EN.
module tb_tlight_monitor;
  import tlight_pkg::*;

`ifdef TLIGHT_MON_DWELL_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  light = 3'b000;
  logic        clear = 1'b0;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic [15:0] cycles;
  logic        err_pulse;
  logic        err;
  logic [2:0]  err_code;
  logic [30:0] obs_vec;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_lq;
  int m_phase, m_dwell, m_cycles, m_code;
  bit m_pulse, m_err;

  tlight_monitor #(
    .RED_MIN (3), .RED_MAX (20),
    .GRN_MIN (3), .GRN_MAX (20),
    .YEL_MIN (1), .YEL_MAX (5),
    .CNT_W   (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .light     (light),
    .clear     (clear),
    .phase     (phase),
    .dwell     (dwell),
    .cycles    (cycles),
    .err_pulse (err_pulse),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  assign obs_vec = {phase, dwell, cycles, err_pulse, err, err_code};

  function automatic logic [30:0] exp_vec();
    return {2'(m_phase), 8'(m_dwell), 16'(m_cycles), m_pulse, m_err, 3'(m_code)};
  endfunction

  // Phase numbering: 0 sync, 1 red, 2 green, 3 yellow; legal successor is p%3+1.
  function automatic int decode(input logic [2:0] l);
    if (l == 3'b100) return 1;
    if (l == 3'b010) return 2;
    if (l == 3'b001) return 3;
    return 0;
  endfunction

  function automatic int min_of(input int p);
    return (p == 3) ? 1 : 3;
  endfunction

  function automatic int max_of(input int p);
    return (p == 3) ? 5 : 20;
  endfunction

  task automatic model_reset();
    m_lq = 3'b000; m_phase = 0; m_dwell = 0; m_cycles = 0;
    m_code = 0; m_pulse = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit clr);
    int o;
    int code;
    o = decode(m_lq);
    code = 0;
    if (m_phase == 0) begin
      if (o != 0) begin m_phase = o; m_dwell = 1; end
    end else if (o == 0) begin
      code = 1; m_phase = 0; m_dwell = 0;
    end else if (o == m_phase) begin
      if (DW_EN && m_dwell == max_of(m_phase)) code = 4;
      if (m_dwell < 255) m_dwell++;
    end else if (o == m_phase % 3 + 1) begin
      if (DW_EN && m_dwell < min_of(m_phase)) code = 3;
      if (m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
      m_phase = o; m_dwell = 1;
    end else begin
      code = 2; m_phase = o; m_dwell = 1;
    end
    m_pulse = (code != 0);
    if (code != 0) begin
      if (!m_err || clr) m_code = code;
      m_err = 1'b1;
    end else if (clr) begin
      m_err = 1'b0; m_code = 0;
    end
  endtask

  task automatic drive(input logic [2:0] l, input bit c);
    light = l;
    clear = c;
    @(posedge clock);
    model_edge(c);
    m_lq = l;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; light = 3'b000; clear = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; light = 3'b010; clear = 1'b0;
    model_reset();
    #3;
    checks++;
    if (obs_vec !== 31'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 31'd0);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    light = 3'b000;
    drive(3'b000, 1'b0);
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_legal_cycles();
    int pk[4];
    pk = '{0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 12; s++) begin
        drive((s < 5) ? LIGHT_R : (s < 10) ? LIGHT_G : LIGHT_Y, 1'b0);
        checks++;
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL legal_step c%0d s%0d got=%h exp=%h", c, s, obs_vec, exp_vec());
        end
        if (int'(dwell) > pk[phase]) pk[phase] = int'(dwell);
      end
    end
    for (int s = 0; s < 5; s++) drive(LIGHT_R, 1'b0);
    checks++;
    if (cycles !== 16'd3) begin
      errors++; $display("FAIL legal_cycles got=%0d exp=3", cycles);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL legal_err got=%b exp=0", err);
    end
    checks++;
    if (pk[1] != 5 || pk[2] != 5 || pk[3] != 2) begin
      errors++; $display("FAIL legal_peaks got=%0d/%0d/%0d exp=5/5/2", pk[1], pk[2], pk[3]);
    end
  endtask

  task automatic test_short_phase();
    int pulses;
    logic [2:0] seq[10];
    seq = '{LIGHT_R, LIGHT_R, LIGHT_R, LIGHT_R, LIGHT_R, LIGHT_G, LIGHT_G, LIGHT_Y, LIGHT_Y, LIGHT_Y};
    pulses = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i], 1'b0);
      pulses += int'(err_pulse);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL short_step%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
    checks++;
    if (phase !== 2'd3) begin
      errors++; $display("FAIL short_phase got=%0d exp=3", phase);
    end
    checks++;
    if (pulses != int'(DW_EN) || err !== DW_EN || err_code !== (DW_EN ? 3'd3 : 3'd0)) begin
      errors++; $display("FAIL short_err got=p%0d e%b c%0d exp=p%0d e%b c%0d",
                         pulses, err, err_code, int'(DW_EN), DW_EN, DW_EN ? 3 : 0);
    end
  endtask

  task automatic test_long_phase();
    int pulses;
    int dw_at_pulse;
    pulses = 0;
    dw_at_pulse = 0;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(LIGHT_R, 1'b0);
      if (err_pulse) begin pulses++; dw_at_pulse = int'(dwell); end
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL long_step%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
    checks++;
    if (dwell !== 8'd25) begin
      errors++; $display("FAIL long_dwell got=%0d exp=25", dwell);
    end
    checks++;
    if (pulses != int'(DW_EN) || dw_at_pulse != (DW_EN ? 21 : 0) || err_code !== (DW_EN ? 3'd4 : 3'd0)) begin
      errors++; $display("FAIL long_err got=p%0d d%0d c%0d exp=p%0d d%0d c%0d", pulses, dw_at_pulse,
                         err_code, int'(DW_EN), DW_EN ? 21 : 0, DW_EN ? 4 : 0);
    end
  endtask

  task automatic test_seq_and_encoding();
    do_reset();
    for (int i = 0; i < 5; i++) drive(LIGHT_R, 1'b0);
    drive(LIGHT_Y, 1'b0);
    drive(LIGHT_Y, 1'b0);
    checks++;
    if (phase !== 2'd3 || dwell !== 8'd1 || err_code !== 3'd2 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL badseq got=ph%0d d%0d c%0d p%b exp=ph3 d1 c2 p1", phase, dwell, err_code, err_pulse);
    end
    drive(3'b110, 1'b0);
    drive(3'b110, 1'b0);
    checks++;
    if (phase !== 2'd0 || err_pulse !== 1'b1 || err_code !== 3'd2 || err !== 1'b1) begin
      errors++; $display("FAIL illegal got=ph%0d p%b c%0d e%b exp=ph0 p1 c2 e1", phase, err_pulse, err_code, err);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL seqenc_model got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_clear_and_reset();
    logic [2:0] seq[6];
    do_reset();
    for (int i = 0; i < 4; i++) drive(LIGHT_R, 1'b0);
    drive(LIGHT_Y, 1'b0);
    drive(LIGHT_Y, 1'b0);
    drive(LIGHT_Y, 1'b1);
    checks++;
    if (err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL clear_idle got=e%b c%0d exp=e0 c0", err, err_code);
    end
    seq = '{3'b000, LIGHT_R, LIGHT_R, LIGHT_R, LIGHT_Y, LIGHT_Y};
    foreach (seq[i]) drive(seq[i], (i == 5) ? 1'b1 : 1'b0);
    checks++;
    if (err !== 1'b1 || err_code !== 3'd2) begin
      errors++; $display("FAIL clear_with_badseq got=e%b c%0d exp=e1 c2", err, err_code);
    end
    drive(LIGHT_R, 1'b0);
    for (int i = 0; i < 3; i++) drive(LIGHT_G, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 31'd0) begin
      errors++; $display("FAIL midrun_reset got=%h exp=%h", obs_vec, 31'd0);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(LIGHT_G, 1'b0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL post_reset_step%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
    end
    checks++;
    if (phase !== 2'd2 || err !== 1'b0) begin
      errors++; $display("FAIL post_reset_reentry got=ph%0d e%b exp=ph2 e0", phase, err);
    end
  endtask

  task automatic test_random();
    logic [2:0] l;
    int len;
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 4) == 0) l = 3'($urandom_range(0, 7));
      else l = 3'b100 >> $urandom_range(0, 2);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        drive(l, ($urandom_range(0, 7) == 0));
        checks++;
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL random_seg%0d_i%0d got=%h exp=%h", seg, i, obs_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_legal_cycles();
    test_short_phase();
    test_long_phase();
    test_seq_and_encoding();
    test_clear_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
